surf_align_sequencer: RTL
=========================

Name: surf_align_sequencer

Overview:
- Wishbone initiator that automatically aligns one SURF link (COUT or DOUT) by driving the SURF control register target's 6-bit address map.
- Sweeps IDELAY taps 0..63 and measures bit errors per tap, then programs the tap at the centre of the widest error-free window.
- Sits in the TURFIO wb_clk_i domain between the housekeeping/control master and the per-SURF register target, and owns the bus while busy.

Parameters:
- INTERVAL, 24'd131072: bit-error counter interval written to BIT_ERROR_COUNT_REG (data[23:0]).
- WAIT_CYCLES, 32'd262144: wb_clk_i cycles waited after the discard read before the counted read; must cover at least one full interval.
- SETTLE_CYCLES, 16'd64: wait after each IDELAY write.
- TIMEOUT, 16'd1023: maximum cycles from cyc/stb assertion to ack.
- MIN_WIDTH, 7'd8: minimum error-free window width for success.

Ports:
- wb_clk_i  in  1  system/Wishbone clock
- wb_rst_n_i  in  1  synchronous active-low reset
- start_i  in  1  one-cycle pulse; ignored while busy_o=1
- target_i  in  1  0=COUT (base 0x00), 1=DOUT (base 0x10); sampled on start_i
- busy_o  out  1  sequence running
- done_o  out  1  one-cycle pulse at end (success or fail)
- fail_o  out  1  sticky result of last run; cleared on start
- fail_code_o  out  2  0=none, 1=bus err/timeout, 2=sysclk not ok (read 0xFFFFFFFF), 3=window < MIN_WIDTH
- eye_center_o  out  6  programmed tap
- eye_width_o  out  7  best window length (0..64)
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone classic master
- wbm_adr_o  out  6  byte address
- wbm_dat_o  out  32  write data
- wbm_sel_o  out  4  always 4'hF
- wbm_dat_i  in  32  read data
- wbm_ack_i, wbm_err_i, wbm_rty_i  in  1 each  err and rty both treated as bus error

Behaviour:
- Reset: all outputs 0; wbm_cyc_o/stb_o low; state IDLE. Reset mid-transaction drops cyc/stb on the next edge; no completion is awaited.
- Offsets from base: IDELAY=+0x4, BITERR=+0x8.
- Bus transaction: cyc and stb rise together and are held, with adr/we/dat, until ack/err/rty or a timeout.
  - The terminating cycle samples dat_i, and cyc/stb deassert on the following edge.
  - At least one idle cycle separates transactions.
  - Timeout counter starts at stb assertion; TIMEOUT cycles without a response gives fail code 1.
- States:
  - IDLE -> SET_INTV on start_i. Clears fail_o and the run trackers; tap=0.
  - SET_INTV: write BITERR <= {8'h0, INTERVAL}.
  - SET_TAP: write IDELAY <= {26'h0, tap}.
  - SETTLE: count SETTLE_CYCLES.
  - RD_DISCARD: read BITERR; data discarded (checked only for 0xFFFFFFFF).
  - WAIT_INTV: count WAIT_CYCLES.
  - RD_COUNT: read BITERR into errcnt.
  - EVAL (one cycle): update run trackers.
  - NEXT: tap==63 -> FINISH, else tap+1 -> SET_TAP.
  - FINISH: if best_len < MIN_WIDTH, fail code 3. Otherwise write IDELAY <= center and go to DONE.
  - DONE: done_o pulse -> IDLE.
  - FAIL: done_o pulse, fail_o=1 -> IDLE.
- Any read returning 32'hFFFFFFFF -> FAIL with code 2. Any bus error or timeout -> FAIL with code 1. On FAIL no centre write is issued.
- Run tracking (7-bit lengths):
  - errcnt==0: if cur_len==0 then cur_start=tap; cur_len++.
  - errcnt!=0: close the run, cur_len=0.
  - A run is also closed after EVAL of tap 63.
  - Close: if cur_len > best_len (strictly greater) then best={cur_start, cur_len}. Ties keep the earliest window.
- center = best_start + best_len[6:1], truncated to 6 bits (never overflows, since start+len ≤ 64).
- eye_center_o/eye_width_o update at FINISH and hold until the next FINISH.
- start_i coincident with reset: reset wins.

Decomposition:
- Shared package surf_align_pkg holds:
  - register offsets (IDELAY, BITERR, CONTROL) and the COUT/DOUT bases;
  - the state enum;
  - the fail code constants.
- One sub-module: wb_single_master. It performs one read/write transaction with timeout. Its interface is req/we/adr/dat in and done/err/rdata out.

Test Plan:
- Target model: errors=0 for taps 20..39, else 5; target_i=0 -> writes to 0x08 (0x020000) then 0x04 per tap; final write 0x04 <= 30; eye_width_o=20, fail_o=0, one done_o pulse.
- Two windows, taps 5..14 (10) and 40..49 (10) -> tie; center=10, width=10.
- All taps error-free, target_i=1 -> addresses 0x14/0x18; center=32, width=64.
- Clean window only at taps 60..63 (len 4 < MIN_WIDTH 8) -> fail_code_o=3, no centre write, done_o pulse.
- Target returns 0xFFFFFFFF on the first BITERR read -> FAIL code 2. Separately, ack withheld -> cyc drops after 1023 cycles with code 1.
- Assert wb_rst_n_i low mid-transaction at tap 17 -> cyc/stb low next cycle, busy_o=0. A subsequent start_i runs cleanly from tap 0.

Source files
------------

// File: rtl/surf_align_pkg.sv
// Shared definitions for the SURF link alignment sequencer: register map,
// sequencer states and result codes.
package surf_align_pkg;

    localparam logic [5:0] BASE_COUT   = 6'h00;
    localparam logic [5:0] BASE_DOUT   = 6'h10;
    localparam logic [5:0] OFS_CONTROL = 6'h0;
    localparam logic [5:0] OFS_IDELAY  = 6'h4;
    localparam logic [5:0] OFS_BITERR  = 6'h8;

    localparam logic [1:0] FC_NONE   = 2'd0;
    localparam logic [1:0] FC_BUS    = 2'd1;
    localparam logic [1:0] FC_SYSCLK = 2'd2;
    localparam logic [1:0] FC_WIDTH  = 2'd3;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SET_INTV,
        ST_SET_TAP,
        ST_SETTLE,
        ST_RD_DISCARD,
        ST_WAIT_INTV,
        ST_RD_COUNT,
        ST_EVAL,
        ST_NEXT,
        ST_FINISH,
        ST_DONE,
        ST_FAIL
    } state_t;

endpackage

// File: rtl/wb_single_master.sv
// Single Wishbone classic transaction engine: one read or write per req pulse,
// terminated by ack, err/rty or a response timeout.
module wb_single_master #(
    parameter logic [15:0] TIMEOUT = 16'd1023
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        req,
    input  logic        we,
    input  logic [5:0]  adr,
    input  logic [31:0] dat,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [5:0]  wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    input  logic        wbm_rty_i
);

    logic        cyc_reg;
    logic        we_reg;
    logic [5:0]  adr_reg;
    logic [31:0] dat_reg;
    logic        done_reg;
    logic        err_reg;
    logic [31:0] rdata_reg;
    logic [15:0] tmo_cnt_reg;

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            cyc_reg     <= 1'b0;
            we_reg      <= 1'b0;
            adr_reg     <= '0;
            dat_reg     <= '0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
            rdata_reg   <= '0;
            tmo_cnt_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            if (!cyc_reg) begin
                if (req) begin
                    cyc_reg     <= 1'b1;
                    we_reg      <= we;
                    adr_reg     <= adr;
                    dat_reg     <= dat;
                    tmo_cnt_reg <= '0;
                end
            end else if (wbm_ack_i || wbm_err_i || wbm_rty_i) begin
                // retry is not supported by the register target, so it counts as an error
                cyc_reg   <= 1'b0;
                done_reg  <= 1'b1;
                err_reg   <= wbm_err_i || wbm_rty_i;
                rdata_reg <= wbm_dat_i;
            end else if (tmo_cnt_reg == TIMEOUT - 16'd1) begin
                cyc_reg  <= 1'b0;
                done_reg <= 1'b1;
                err_reg  <= 1'b1;
            end else begin
                tmo_cnt_reg <= tmo_cnt_reg + 16'd1;
            end
        end
    end

    assign done      = done_reg;
    assign err       = err_reg;
    assign rdata     = rdata_reg;
    assign wbm_cyc_o = cyc_reg;
    assign wbm_stb_o = cyc_reg;
    assign wbm_we_o  = we_reg;
    assign wbm_adr_o = adr_reg;
    assign wbm_dat_o = dat_reg;
    assign wbm_sel_o = 4'hF;

endmodule

// File: rtl/surf_align_sequencer.sv
// Automatic IDELAY eye scan for one SURF link: sweeps all taps, measures bit
// errors per tap and programs the centre of the widest error-free window.
module surf_align_sequencer
    import surf_align_pkg::*;
#(
    parameter logic [23:0] INTERVAL      = 24'd131072,
    parameter logic [31:0] WAIT_CYCLES   = 32'd262144,
    parameter logic [15:0] SETTLE_CYCLES = 16'd64,
    parameter logic [15:0] TIMEOUT       = 16'd1023,
    parameter logic [6:0]  MIN_WIDTH     = 7'd8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        start_i,
    input  logic        target_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        fail_o,
    output logic [1:0]  fail_code_o,
    output logic [5:0]  eye_center_o,
    output logic [6:0]  eye_width_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [5:0]  wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    input  logic        wbm_rty_i
);

    state_t      state_reg, state_next;
    logic [5:0]  base_reg, base_next;
    logic [5:0]  tap_reg, tap_next;
    logic [31:0] wait_cnt_reg, wait_cnt_next;
    logic [31:0] errcnt_reg, errcnt_next;
    logic [5:0]  cur_start_reg, cur_start_next;
    logic [6:0]  cur_len_reg, cur_len_next;
    logic [5:0]  best_start_reg, best_start_next;
    logic [6:0]  best_len_reg, best_len_next;
    logic        req_sent_reg, req_sent_next;
    logic        fail_reg, fail_next;
    logic [1:0]  fail_code_reg, fail_code_next;
    logic [5:0]  eye_center_reg, eye_center_next;
    logic [6:0]  eye_width_reg, eye_width_next;

    logic        m_req, m_we, m_done, m_err;
    logic [5:0]  m_adr;
    logic [31:0] m_dat, m_rdata;
    logic        bus_active;
    logic        wr_ok, rd_ok;
    logic [5:0]  center;
    logic [6:0]  len_after;
    logic [5:0]  start_after;
    logic        run_close;

    wb_single_master #(
        .TIMEOUT(TIMEOUT)
    ) u_master (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_n_i (wb_rst_n_i),
        .req        (m_req),
        .we         (m_we),
        .adr        (m_adr),
        .dat        (m_dat),
        .done       (m_done),
        .err        (m_err),
        .rdata      (m_rdata),
        .wbm_cyc_o  (wbm_cyc_o),
        .wbm_stb_o  (wbm_stb_o),
        .wbm_we_o   (wbm_we_o),
        .wbm_adr_o  (wbm_adr_o),
        .wbm_dat_o  (wbm_dat_o),
        .wbm_sel_o  (wbm_sel_o),
        .wbm_dat_i  (wbm_dat_i),
        .wbm_ack_i  (wbm_ack_i),
        .wbm_err_i  (wbm_err_i),
        .wbm_rty_i  (wbm_rty_i)
    );

    // An all-ones read means the target's sysclk is not running.
    assign wr_ok = m_done && !m_err;
    assign rd_ok = wr_ok && (m_rdata != 32'hFFFF_FFFF);

    // Run tracker: a clean tap extends the current run; a dirty tap or the
    // last tap closes it against the best run so far (strictly longer wins).
    assign len_after   = (errcnt_reg == 32'd0) ? cur_len_reg + 7'd1 : cur_len_reg;
    assign start_after = (errcnt_reg == 32'd0 && cur_len_reg == 7'd0) ? tap_reg : cur_start_reg;
    assign run_close   = (errcnt_reg != 32'd0) || (tap_reg == 6'd63);
    assign center      = best_start_reg + best_len_reg[6:1];

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            state_reg      <= ST_IDLE;
            base_reg       <= '0;
            tap_reg        <= '0;
            wait_cnt_reg   <= '0;
            errcnt_reg     <= '0;
            cur_start_reg  <= '0;
            cur_len_reg    <= '0;
            best_start_reg <= '0;
            best_len_reg   <= '0;
            req_sent_reg   <= 1'b0;
            fail_reg       <= 1'b0;
            fail_code_reg  <= FC_NONE;
            eye_center_reg <= '0;
            eye_width_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            base_reg       <= base_next;
            tap_reg        <= tap_next;
            wait_cnt_reg   <= wait_cnt_next;
            errcnt_reg     <= errcnt_next;
            cur_start_reg  <= cur_start_next;
            cur_len_reg    <= cur_len_next;
            best_start_reg <= best_start_next;
            best_len_reg   <= best_len_next;
            req_sent_reg   <= req_sent_next;
            fail_reg       <= fail_next;
            fail_code_reg  <= fail_code_next;
            eye_center_reg <= eye_center_next;
            eye_width_reg  <= eye_width_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        base_next       = base_reg;
        tap_next        = tap_reg;
        wait_cnt_next   = '0;
        errcnt_next     = errcnt_reg;
        cur_start_next  = cur_start_reg;
        cur_len_next    = cur_len_reg;
        best_start_next = best_start_reg;
        best_len_next   = best_len_reg;
        fail_next       = fail_reg;
        fail_code_next  = fail_code_reg;
        eye_center_next = eye_center_reg;
        eye_width_next  = eye_width_reg;
        bus_active      = 1'b0;
        m_we            = 1'b0;
        m_adr           = '0;
        m_dat           = '0;

        case (state_reg)
            ST_IDLE: begin
                if (start_i) begin
                    state_next      = ST_SET_INTV;
                    base_next       = target_i ? BASE_DOUT : BASE_COUT;
                    tap_next        = '0;
                    cur_start_next  = '0;
                    cur_len_next    = '0;
                    best_start_next = '0;
                    best_len_next   = '0;
                    fail_next       = 1'b0;
                    fail_code_next  = FC_NONE;
                end
            end
            ST_SET_INTV: begin
                bus_active = 1'b1;
                m_we       = 1'b1;
                m_adr      = base_reg + OFS_BITERR;
                m_dat      = {8'h00, INTERVAL};
                if (wr_ok) state_next = ST_SET_TAP;
            end
            ST_SET_TAP: begin
                bus_active = 1'b1;
                m_we       = 1'b1;
                m_adr      = base_reg + OFS_IDELAY;
                m_dat      = {26'h0, tap_reg};
                if (wr_ok) state_next = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (wait_cnt_reg + 32'd1 >= {16'h0, SETTLE_CYCLES}) state_next = ST_RD_DISCARD;
                else wait_cnt_next = wait_cnt_reg + 32'd1;
            end
            ST_RD_DISCARD: begin
                bus_active = 1'b1;
                m_adr      = base_reg + OFS_BITERR;
                if (rd_ok) state_next = ST_WAIT_INTV;
            end
            ST_WAIT_INTV: begin
                if (wait_cnt_reg + 32'd1 >= WAIT_CYCLES) state_next = ST_RD_COUNT;
                else wait_cnt_next = wait_cnt_reg + 32'd1;
            end
            ST_RD_COUNT: begin
                bus_active = 1'b1;
                m_adr      = base_reg + OFS_BITERR;
                if (rd_ok) begin
                    errcnt_next = m_rdata;
                    state_next  = ST_EVAL;
                end
            end
            ST_EVAL: begin
                cur_start_next = start_after;
                cur_len_next   = run_close ? 7'd0 : len_after;
                if (run_close && len_after > best_len_reg) begin
                    best_start_next = start_after;
                    best_len_next   = len_after;
                end
                state_next = ST_NEXT;
            end
            ST_NEXT: begin
                if (tap_reg == 6'd63) begin
                    state_next = ST_FINISH;
                end else begin
                    tap_next   = tap_reg + 6'd1;
                    state_next = ST_SET_TAP;
                end
            end
            ST_FINISH: begin
                if (!req_sent_reg) begin
                    eye_center_next = center;
                    eye_width_next  = best_len_reg;
                end
                if (best_len_reg < MIN_WIDTH) begin
                    state_next     = ST_FAIL;
                    fail_code_next = FC_WIDTH;
                end else begin
                    bus_active = 1'b1;
                    m_we       = 1'b1;
                    m_adr      = base_reg + OFS_IDELAY;
                    m_dat      = {26'h0, center};
                    if (wr_ok) state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            ST_FAIL: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase

        if (bus_active && m_done && !(m_we ? wr_ok : rd_ok)) begin
            state_next     = ST_FAIL;
            fail_code_next = m_err ? FC_BUS : FC_SYSCLK;
        end
        if (state_next == ST_FAIL) fail_next = 1'b1;

        // One request per bus state; the flag drops when the transaction completes.
        m_req         = bus_active && !req_sent_reg;
        req_sent_next = bus_active && !m_done;
    end

    assign busy_o       = (state_reg != ST_IDLE);
    assign done_o       = (state_reg == ST_DONE) || (state_reg == ST_FAIL);
    assign fail_o       = fail_reg;
    assign fail_code_o  = fail_code_reg;
    assign eye_center_o = eye_center_reg;
    assign eye_width_o  = eye_width_reg;

endmodule
